// File: rtl/fifo_occupancy_monitor_pkg.sv
// Shared definitions for the FIFO occupancy monitor: read-select field codes,
// flag bit positions and the channel/field split of the read select.
package fifo_occupancy_monitor_pkg;

   typedef enum logic [1:0] {
      FLD_DEPTH = 2'd0,
      FLD_MAX   = 2'd1,
      FLD_EVT   = 2'd2,
      FLD_FLAGS = 2'd3
   } field_e;

   localparam int FLG_OVF  = 0;
   localparam int FLG_UDF  = 1;
   localparam int FLG_W    = 2;

   localparam int RD_SEL_W = 8;
   localparam int RD_FLD_W = 2;
   localparam int RD_CH_W  = RD_SEL_W - RD_FLD_W;

   function automatic logic [RD_CH_W-1:0] sel_channel(input logic [RD_SEL_W-1:0] sel);
      return sel[RD_SEL_W-1:RD_FLD_W];
   endfunction

   function automatic field_e sel_field(input logic [RD_SEL_W-1:0] sel);
      return field_e'(sel[RD_FLD_W-1:0]);
   endfunction

endpackage

// File: rtl/fifo_occupancy_monitor_if.sv
// Strobe, threshold, read-port and status bundle between the monitored FIFOs,
// the register block and the occupancy monitor.
interface fifo_occupancy_monitor_if
   import fifo_occupancy_monitor_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_NUM_CH           = 4,
   parameter int C_CNT_WIDTH        = 16
);
   logic [C_NUM_CH-1:0]             fifo_wren;
   logic [C_NUM_CH-1:0]             fifo_rden;
   logic [C_NUM_CH-1:0]             clear;
   logic [C_CNT_WIDTH-1:0]          threshold;
   logic [RD_SEL_W-1:0]             rd_sel;
   logic                            rd_en;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data;
   logic                            rd_valid;
   logic [C_NUM_CH*C_CNT_WIDTH-1:0] fifo_depth;
   logic [C_NUM_CH*C_CNT_WIDTH-1:0] fifo_depth_max;
   logic [C_NUM_CH-1:0]             over_thresh;

   modport master (
      output fifo_wren, fifo_rden, clear, threshold, rd_sel, rd_en,
      input  rd_data, rd_valid, fifo_depth, fifo_depth_max, over_thresh
   );

   modport slave (
      input  fifo_wren, fifo_rden, clear, threshold, rd_sel, rd_en,
      output rd_data, rd_valid, fifo_depth, fifo_depth_max, over_thresh
   );
endinterface

// File: rtl/fifo_occupancy_channel.sv
// One monitored FIFO: saturating depth counter, high watermark, threshold alarm,
// alarm-rising event counter and sticky overflow/underflow flags.
module fifo_occupancy_channel
   import fifo_occupancy_monitor_pkg::*;
#(
   parameter int C_CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_wr,
   input  logic                   i_rd,
   input  logic                   i_clr,
   input  logic [C_CNT_WIDTH-1:0] i_threshold,
   output logic [C_CNT_WIDTH-1:0] o_depth,
   output logic [C_CNT_WIDTH-1:0] o_max,
   output logic [C_CNT_WIDTH-1:0] o_events,
   output logic [FLG_W-1:0]       o_flags,
   output logic                   o_over
);
   localparam logic [C_CNT_WIDTH-1:0] C_ALL_ONES = '1;

   logic [C_CNT_WIDTH-1:0] r_depth, r_max, r_events;
   logic [C_CNT_WIDTH-1:0] w_next_depth, w_next_max, w_next_events;
   logic [FLG_W-1:0]       r_flags, w_next_flags;
   logic                   r_over, w_next_over;
   logic                   w_inc, w_dec;

   assign w_inc = i_wr & ~i_rd;
   assign w_dec = i_rd & ~i_wr;

   always_comb begin
      w_next_depth = r_depth;
      w_next_flags = r_flags;
      if (i_clr) begin
         w_next_depth = '0;
         w_next_flags = '0;
      end else if (w_inc) begin
         if (r_depth == C_ALL_ONES) begin
            w_next_flags[FLG_OVF] = 1'b1;
         end else begin
            w_next_depth = r_depth + C_CNT_WIDTH'(1);
         end
      end else if (w_dec) begin
         if (r_depth == '0) begin
            w_next_flags[FLG_UDF] = 1'b1;
         end else begin
            w_next_depth = r_depth - C_CNT_WIDTH'(1);
         end
      end else begin
         w_next_depth = r_depth;
      end
   end

   // Watermark and alarm follow the next depth so they move on the same edge as depth.
   always_comb begin
      w_next_over   = (i_threshold != '0) && (w_next_depth >= i_threshold);
      w_next_max    = r_max;
      w_next_events = r_events;
      if (i_clr) begin
         w_next_max    = '0;
         w_next_events = '0;
      end else begin
         if (w_next_depth > r_max) begin
            w_next_max = w_next_depth;
         end else begin
            w_next_max = r_max;
         end
         if (w_next_over && !r_over && (r_events != C_ALL_ONES)) begin
            w_next_events = r_events + C_CNT_WIDTH'(1);
         end else begin
            w_next_events = r_events;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_depth  <= '0;
         r_max    <= '0;
         r_events <= '0;
         r_flags  <= '0;
         r_over   <= 1'b0;
      end else begin
         r_depth  <= w_next_depth;
         r_max    <= w_next_max;
         r_events <= w_next_events;
         r_flags  <= w_next_flags;
         r_over   <= w_next_over;
      end
   end

   assign o_depth  = r_depth;
   assign o_max    = r_max;
   assign o_events = r_events;
   assign o_flags  = r_flags;
   assign o_over   = r_over;
endmodule

// File: rtl/fifo_occupancy_monitor.sv
// Multi-channel FIFO occupancy monitor: registers the strobes, runs one counter
// channel per FIFO, packs the status vectors and serves a registered read port.
module fifo_occupancy_monitor
   import fifo_occupancy_monitor_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_NUM_CH           = 4,
   parameter int C_CNT_WIDTH        = 16
) (
   input  logic                    axi_aclk,
   input  logic                    axi_resetn,
   fifo_occupancy_monitor_if.slave mon
);
   logic [C_NUM_CH-1:0]             r_wren, r_rden, r_clear;
   logic [C_CNT_WIDTH-1:0]          w_depth  [C_NUM_CH];
   logic [C_CNT_WIDTH-1:0]          w_max    [C_NUM_CH];
   logic [C_CNT_WIDTH-1:0]          w_events [C_NUM_CH];
   logic [FLG_W-1:0]                w_flags  [C_NUM_CH];
   logic [C_S_AXI_DATA_WIDTH-1:0]   w_fld_val[C_NUM_CH];
   logic [C_NUM_CH-1:0]             w_over;
   logic [C_NUM_CH*C_CNT_WIDTH-1:0] w_depth_pk, w_max_pk;
   logic [RD_CH_W-1:0]              w_sel_ch;
   field_e                          w_sel_fld;
   logic [C_S_AXI_DATA_WIDTH-1:0]   w_rd_data;
   logic [C_S_AXI_DATA_WIDTH-1:0]   r_rd_data;
   logic                            r_rd_valid;

   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         r_wren  <= '0;
         r_rden  <= '0;
         r_clear <= '0;
      end else begin
         r_wren  <= mon.fifo_wren;
         r_rden  <= mon.fifo_rden;
         r_clear <= mon.clear;
      end
   end

   assign w_sel_ch  = sel_channel(mon.rd_sel);
   assign w_sel_fld = sel_field(mon.rd_sel);

   for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
      fifo_occupancy_channel #(
         .C_CNT_WIDTH (C_CNT_WIDTH)
      ) u_ch (
         .clk         (axi_aclk),
         .rst_n       (axi_resetn),
         .i_wr        (r_wren[g]),
         .i_rd        (r_rden[g]),
         .i_clr       (r_clear[g]),
         .i_threshold (mon.threshold),
         .o_depth     (w_depth[g]),
         .o_max       (w_max[g]),
         .o_events    (w_events[g]),
         .o_flags     (w_flags[g]),
         .o_over      (w_over[g])
      );

      always_comb begin
         case (w_sel_fld)
            FLD_DEPTH: w_fld_val[g] = C_S_AXI_DATA_WIDTH'(w_depth[g]);
            FLD_MAX:   w_fld_val[g] = C_S_AXI_DATA_WIDTH'(w_max[g]);
            FLD_EVT:   w_fld_val[g] = C_S_AXI_DATA_WIDTH'(w_events[g]);
            FLD_FLAGS: w_fld_val[g] = C_S_AXI_DATA_WIDTH'(w_flags[g]);
            default:   w_fld_val[g] = '0;
         endcase
      end
   end

   // Unmatched channel numbers select nothing, so out-of-range reads return zero.
   always_comb begin
      w_rd_data  = '0;
      w_depth_pk = '0;
      w_max_pk   = '0;
      for (int k = 0; k < C_NUM_CH; k++) begin
         w_rd_data = w_rd_data |
                     (w_fld_val[k] & {C_S_AXI_DATA_WIDTH{w_sel_ch == RD_CH_W'(k)}});
         w_depth_pk[k*C_CNT_WIDTH +: C_CNT_WIDTH] = w_depth[k];
         w_max_pk[k*C_CNT_WIDTH +: C_CNT_WIDTH]   = w_max[k];
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= mon.rd_en;
         if (mon.rd_en) begin
            r_rd_data <= w_rd_data;
         end else begin
            r_rd_data <= r_rd_data;
         end
      end
   end

   assign mon.rd_data        = r_rd_data;
   assign mon.rd_valid       = r_rd_valid;
   assign mon.fifo_depth     = w_depth_pk;
   assign mon.fifo_depth_max = w_max_pk;
   assign mon.over_thresh    = w_over;
endmodule

// File: tb/tb_fifo_occupancy_monitor.sv
// Directed bench for fifo_occupancy_monitor with 4-bit counters; read-port
// expectations go through a scoreboard queue and are popped when rd_valid arrives.
module tb_fifo_occupancy_monitor;
   import fifo_occupancy_monitor_pkg::*;

   localparam int DW  = 32;
   localparam int NCH = 4;
   localparam int CW  = 4;

   logic          axi_aclk   = 1'b0;
   logic          axi_resetn = 1'b0;
   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] exp_q[$];

   fifo_occupancy_monitor_if #(
      .C_S_AXI_DATA_WIDTH (DW), .C_NUM_CH (NCH), .C_CNT_WIDTH (CW)
   ) mon ();

   fifo_occupancy_monitor #(
      .C_S_AXI_DATA_WIDTH (DW), .C_NUM_CH (NCH), .C_CNT_WIDTH (CW)
   ) dut (
      .axi_aclk   (axi_aclk),
      .axi_resetn (axi_resetn),
      .mon        (mon)
   );

   always #5 axi_aclk = ~axi_aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] dep(input int ch);
      return DW'(mon.fifo_depth[ch*CW +: CW]);
   endfunction

   function automatic logic [DW-1:0] mx(input int ch);
      return DW'(mon.fifo_depth_max[ch*CW +: CW]);
   endfunction

   task automatic strobe(input logic [NCH-1:0] wr, input logic [NCH-1:0] rd,
                         input logic [NCH-1:0] clr, input int n);
      mon.fifo_wren = wr;
      mon.fifo_rden = rd;
      mon.clear     = clr;
      repeat (n) cyc();
      mon.fifo_wren = '0;
      mon.fifo_rden = '0;
      mon.clear     = '0;
   endtask

   task automatic do_read(input int ch, input int fld, input logic [DW-1:0] exp);
      int waited;
      waited = 0;
      mon.rd_sel = 8'(ch * 4 + fld);
      mon.rd_en  = 1'b1;
      exp_q.push_back(exp);
      cyc();
      mon.rd_en = 1'b0;
      while (!mon.rd_valid && waited < 4) begin
         cyc();
         waited++;
      end
      check("rd_latency", DW'(waited), 32'd0);
      if (mon.rd_valid) begin
         check("rd_data", mon.rd_data, exp_q.pop_front());
         cyc();
         check("rd_valid_pulse", DW'(mon.rd_valid), 32'd0);
      end else begin
         exp_q.delete(0);
      end
   endtask

   initial begin
      mon.fifo_wren = '0;
      mon.fifo_rden = '0;
      mon.clear     = '0;
      mon.threshold = '0;
      mon.rd_sel    = '0;
      mon.rd_en     = 1'b0;

      // reset state
      repeat (3) cyc();
      check("rst_depth", DW'(mon.fifo_depth), 32'd0);
      check("rst_max", DW'(mon.fifo_depth_max), 32'd0);
      check("rst_over", DW'(mon.over_thresh), 32'd0);
      check("rst_rd_valid", DW'(mon.rd_valid), 32'd0);
      check("rst_rd_data", mon.rd_data, 32'd0);
      axi_resetn = 1'b1;
      cyc();

      // 1: ch0 five writes then two reads, with two-edge latency
      mon.fifo_wren = 4'b0001;
      cyc();
      check("lat_edge1", dep(0), 32'd0);
      cyc();
      check("lat_edge2", dep(0), 32'd1);
      strobe(4'b0001, 4'b0000, 4'b0000, 3);
      cyc();
      check("t1_depth5", dep(0), 32'd5);
      check("t1_max5", mx(0), 32'd5);
      strobe(4'b0000, 4'b0001, 4'b0000, 2);
      cyc();
      check("t1_depth3", dep(0), 32'd3);
      check("t1_max_hold", mx(0), 32'd5);
      do_read(0, int'(FLD_FLAGS), 32'd0);

      // 2: simultaneous wr+rd is a no-op; read at empty sets underflow
      strobe(4'b0010, 4'b0010, 4'b0000, 10);
      cyc();
      check("t2_ch1_depth", dep(1), 32'd0);
      check("t2_ch1_max", mx(1), 32'd0);
      do_read(1, int'(FLD_FLAGS), 32'd0);
      strobe(4'b0000, 4'b0100, 4'b0000, 1);
      cyc();
      check("t2_ch2_depth", dep(2), 32'd0);
      do_read(2, int'(FLD_FLAGS), 32'd2);

      // 3: saturation at all-ones, then clear wins over a coincident write
      strobe(4'b1000, 4'b0000, 4'b0000, 20);
      cyc();
      check("t3_depth_sat", dep(3), 32'd15);
      check("t3_max_sat", mx(3), 32'd15);
      do_read(3, int'(FLD_FLAGS), 32'd1);
      strobe(4'b1000, 4'b0000, 4'b1000, 1);
      check("t3_clr_edge1", dep(3), 32'd15);
      cyc();
      check("t3_clr_depth", dep(3), 32'd0);
      check("t3_clr_max", mx(3), 32'd0);
      check("t3_other_ch", dep(0), 32'd3);
      do_read(3, int'(FLD_FLAGS), 32'd0);
      do_read(3, int'(FLD_EVT), 32'd0);

      // 4: threshold alarm and rising-edge event counting
      mon.threshold = 4'd4;
      cyc();
      check("t4_below", DW'(mon.over_thresh), 32'd0);
      strobe(4'b0001, 4'b0000, 4'b0000, 1);
      cyc();
      check("t4_over1", DW'(mon.over_thresh), 32'd1);
      strobe(4'b0000, 4'b0001, 4'b0000, 1);
      cyc();
      check("t4_under", DW'(mon.over_thresh), 32'd0);
      strobe(4'b0001, 4'b0000, 4'b0000, 1);
      cyc();
      check("t4_over2", DW'(mon.over_thresh), 32'd1);
      check("t4_max_hold", mx(0), 32'd5);
      do_read(0, int'(FLD_EVT), 32'd2);
      mon.threshold = 4'd0;
      cyc();
      check("t4_thr0_off", DW'(mon.over_thresh), 32'd0);
      mon.threshold = 4'd3;
      cyc();
      check("t4_thr_change", DW'(mon.over_thresh), 32'd1);
      do_read(0, int'(FLD_EVT), 32'd3);
      mon.threshold = 4'd0;
      cyc();

      // 5: read port fields, out-of-range channel, read with coincident clear
      strobe(4'b0100, 4'b0000, 4'b0000, 3);
      strobe(4'b0000, 4'b0100, 4'b0000, 2);
      cyc();
      check("t5_ch2_depth", dep(2), 32'd1);
      do_read(2, int'(FLD_MAX), 32'd3);
      do_read(7, int'(FLD_DEPTH), 32'd0);
      do_read(2, int'(FLD_FLAGS), 32'd2);
      do_read(0, int'(FLD_DEPTH), 32'd4);
      mon.clear = 4'b0001;
      do_read(0, int'(FLD_MAX), 32'd5);
      mon.clear = 4'b0000;
      cyc();
      check("t5_clr_max0", mx(0), 32'd0);
      check("t5_clr_depth0", dep(0), 32'd0);
      check("t5_ch2_kept", dep(2), 32'd1);

      // 6: reset with strobes and a read in flight
      mon.fifo_wren = 4'b0010;
      mon.rd_en     = 1'b1;
      cyc();
      axi_resetn = 1'b0;
      cyc();
      check("t6_rst_depth", DW'(mon.fifo_depth), 32'd0);
      check("t6_rst_max", DW'(mon.fifo_depth_max), 32'd0);
      check("t6_rst_valid", DW'(mon.rd_valid), 32'd0);
      check("t6_rst_data", mon.rd_data, 32'd0);
      mon.fifo_wren = '0;
      mon.rd_en     = 1'b0;
      axi_resetn    = 1'b1;
      cyc();
      cyc();
      check("t6_no_stale", dep(1), 32'd0);
      check("t6_over", DW'(mon.over_thresh), 32'd0);
      do_read(2, int'(FLD_MAX), 32'd0);
      do_read(2, int'(FLD_FLAGS), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
